// File: rtl/multu_hilo_if.sv
// -----------------------------------------------------------------------------
// multu_hilo_if
//   Bundles the operand/command inputs and the HI/LO/status outputs of the
//   multiply unit into one connection.
//   master : the issuing side (decode/ALU); drives dataA, dataB and Signal and
//            reads HiOut, LoOut, busy and done.
//   slave  : the multiply unit itself.
// Signals
//   dataA, dataB  WIDTH  multiplicand / multiplier
//   Signal        6      funct code
//   HiOut, LoOut  WIDTH  architectural HI / LO registers
//   busy          1      multiply in progress
//   done          1      one-cycle pulse, HI/LO just updated
// -----------------------------------------------------------------------------
interface multu_hilo_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] dataA;
   logic [WIDTH-1:0] dataB;
   logic [5:0]       Signal;
   logic [WIDTH-1:0] HiOut;
   logic [WIDTH-1:0] LoOut;
   logic             busy;
   logic             done;

   modport master (
      output dataA, dataB, Signal,
      input  HiOut, LoOut, busy, done
   );

   modport slave (
      input  dataA, dataB, Signal,
      output HiOut, LoOut, busy, done
   );
endinterface

// File: rtl/multu_hilo_unit.sv
// -----------------------------------------------------------------------------
// multu_hilo_unit
//   Sequential WIDTHxWIDTH unsigned shift-add multiplier holding the HI/LO
//   registers. A MULTU funct code in IDLE or DONE starts a multiply that takes
//   one iteration per clock for WIDTH clocks; the full product is then written
//   to HI/LO and done pulses for one cycle. HI/LO keep the previous result
//   while the multiply runs, so MFHI/MFLO never stall.
// Ports
//   clk    : clock, all state changes on the rising edge
//   reset  : synchronous active-high reset, aborts a running multiply
//   bus    : multu_hilo_if.slave (dataA, dataB, Signal in;
//            HiOut, LoOut, busy, done out)
// -----------------------------------------------------------------------------
module multu_hilo_unit #(
   parameter int         WIDTH       = 32,
   parameter logic [5:0] MULTU_FUNCT = 6'd25
) (
   input  logic               clk,
   input  logic               reset,
   multu_hilo_if.slave        bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q,   state_d;
   logic [2*WIDTH-1:0] mcand_q,   mcand_d;
   logic [WIDTH-1:0]   mplier_q,  mplier_d;
   logic [2*WIDTH-1:0] product_q, product_d;
   logic [CW-1:0]      count_q,   count_d;
   logic [WIDTH-1:0]   hi_q,      hi_d;
   logic [WIDTH-1:0]   lo_q,      lo_d;

   // Product after this cycle's conditional add; used both to advance the
   // partial product and, on the last iteration, to load HI/LO directly so no
   // extra cycle is spent copying product into HI/LO.
   logic [2*WIDTH-1:0] sum;
   logic               start;

   assign sum   = product_q + (mplier_q[0] ? mcand_q : '0);
   assign start = (bus.Signal == MULTU_FUNCT);

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      product_d = product_q;
      count_d   = count_q;
      hi_d      = hi_q;
      lo_d      = lo_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               mcand_d   = {{WIDTH{1'b0}}, bus.dataA};
               mplier_d  = bus.dataB;
               product_d = '0;
               count_d   = '0;
               state_d   = MULT;
            end else begin
               state_d   = IDLE;
            end
         end
         MULT: begin
            // A new request here is deliberately dropped, not queued.
            product_d = sum;
            mcand_d   = mcand_q << 1;
            mplier_d  = mplier_q >> 1;
            count_d   = count_q + 1'b1;
            if (count_q == CW'(WIDTH - 1)) begin
               hi_d    = sum[2*WIDTH-1:WIDTH];
               lo_d    = sum[WIDTH-1:0];
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         mplier_q  <= '0;
         product_q <= '0;
         count_q   <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         product_q <= product_d;
         count_q   <= count_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign bus.HiOut = hi_q;
   assign bus.LoOut = lo_q;
   assign bus.busy  = (state_q == MULT);
   assign bus.done  = (state_q == DONE);

endmodule

// File: tb/tb_multu_hilo_unit.sv
// -----------------------------------------------------------------------------
// tb_multu_hilo_unit
//   Drives multiplies through multu_hilo_if; every accepted request pushes its
//   expected {HI,LO} into a queue, and a monitor pops and compares whenever
//   done pulses.
// -----------------------------------------------------------------------------
module tb_multu_hilo_unit;

   localparam int         WIDTH = 32;
   localparam logic [5:0] MULTU = 6'd25;

   logic clk;
   logic reset;

   multu_hilo_if #(.WIDTH(WIDTH)) bus ();

   multu_hilo_unit #(.WIDTH(WIDTH), .MULTU_FUNCT(MULTU)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   logic [63:0] exp_q[$];
   logic        prev_done = 1'b0;

   task automatic check_eq(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a MULTU and let the accepting edge pass; expected product queued.
   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      bus.dataA  = a;
      bus.dataB  = b;
      bus.Signal = MULTU;
      exp_q.push_back(64'(a) * 64'(b));
      step();
      bus.Signal = 6'd0;
      bus.dataA  = $urandom;
      bus.dataB  = $urandom;
      check_eq("busy_after_accept", 64'(bus.busy), 64'd1);
      $display("issue a=%h b=%h", a, b);
   endtask

   // Wait for done; 'elapsed' is the number of cycles already stepped since
   // the accepting edge.
   task automatic wait_done(input int elapsed);
      int n;
      n = elapsed;
      while (!bus.done && n < 100) begin
         step();
         n++;
      end
      check_eq("latency", 64'(n), 64'(WIDTH));
   endtask

   // Monitor: compare HI/LO against the scoreboard every time done pulses.
   initial begin
      forever begin
         step();
         if (bus.done) begin
            check_eq("done_single", 64'(prev_done), 64'd0);
            check_eq("busy_in_done", 64'(bus.busy), 64'd0);
            if (exp_q.size() == 0) begin
               check_eq("unexpected_done", 64'd1, 64'd0);
            end else begin
               logic [63:0] e;
               e = exp_q.pop_front();
               check_eq("hilo", {bus.HiOut, bus.LoOut}, e);
               $display("result hi=%h lo=%h", bus.HiOut, bus.LoOut);
            end
         end
         prev_done = bus.done;
      end
   end

   initial begin
      logic [63:0] prev;

      // 1. reset
      reset      = 1'b1;
      bus.Signal = 6'd0;
      bus.dataA  = '0;
      bus.dataB  = '0;
      step();
      step();
      reset = 1'b0;
      step();
      check_eq("rst_hi",   64'(bus.HiOut), 64'd0);
      check_eq("rst_lo",   64'(bus.LoOut), 64'd0);
      check_eq("rst_busy", 64'(bus.busy),  64'd0);
      check_eq("rst_done", 64'(bus.done),  64'd0);

      // Non-MULTU codes do nothing.
      bus.Signal = 6'd24;
      bus.dataA  = 32'd9;
      bus.dataB  = 32'd9;
      step();
      bus.Signal = 6'd0;
      check_eq("nonmultu_busy", 64'(bus.busy), 64'd0);
      check_eq("nonmultu_lo",   64'(bus.LoOut), 64'd0);

      // 2. 3*5, busy for 32 cycles
      issue(32'd3, 32'd5);
      for (int i = 1; i < WIDTH; i++) begin
         step();
         if (i == 31) check_eq("busy_31", 64'(bus.busy), 64'd1);
      end
      step();
      check_eq("done_at_32", 64'(bus.done), 64'd1);
      step();
      check_eq("done_drop", 64'(bus.done), 64'd0);
      check_eq("idle_busy", 64'(bus.busy), 64'd0);

      // 3. corner operands
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(0);
      issue(32'h8000_0000, 32'd2);
      wait_done(0);
      issue(32'd0, 32'd1234);
      wait_done(0);
      for (int i = 0; i < 3; i++) begin
         issue($urandom, $urandom);
         wait_done(0);
      end
      step();

      // 4. MULTU during busy ignored, HI/LO hold the old result
      prev = {bus.HiOut, bus.LoOut};
      issue(32'd3, 32'd5);
      for (int i = 0; i < 9; i++) begin
         step();
         check_eq("hold_hilo", {bus.HiOut, bus.LoOut}, prev);
      end
      bus.Signal = MULTU;
      bus.dataA  = 32'd7;
      bus.dataB  = 32'd7;
      step();
      bus.Signal = 6'd0;
      check_eq("hold_after_ign", {bus.HiOut, bus.LoOut}, prev);
      wait_done(10);
      step();
      check_eq("ignored_not_queued", 64'(bus.busy), 64'd0);

      // 5. reset mid-multiply
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      for (int i = 0; i < 9; i++) step();
      reset = 1'b1;
      exp_q.delete();
      step();
      reset = 1'b0;
      check_eq("abort_busy", 64'(bus.busy),  64'd0);
      check_eq("abort_hi",   64'(bus.HiOut), 64'd0);
      check_eq("abort_lo",   64'(bus.LoOut), 64'd0);
      check_eq("abort_done", 64'(bus.done),  64'd0);
      for (int i = 0; i < 40; i++) step();
      check_eq("abort_idle", 64'(bus.busy), 64'd0);

      // 6. back-to-back: second MULTU issued in the DONE cycle
      issue(32'd6, 32'd7);
      wait_done(0);
      check_eq("b2b_lo1", 64'(bus.LoOut), 64'd42);
      issue(32'd2, 32'd9);
      wait_done(0);
      check_eq("b2b_lo2", 64'(bus.LoOut), 64'd18);
      step();
      check_eq("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
